// File: rtl/fir_tap_sequencer.sv
// Control sequencer for one FIR_Tap MAC datapath: stores each accepted sample in
// the circular delay line, walks every tap and captures the accumulated result.
module fir_tap_sequencer #(
  parameter int TAP_ADDR_W = 8,
  parameter int NUM_TAPS   = 256,
  parameter int RD_LAT     = 1,
  parameter int MULT_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [23:0]           sample_in,
  output logic                  busy,
  output logic                  overrun,
  output logic                  sample_we,
  output logic [TAP_ADDR_W-1:0] sample_addr,
  output logic [23:0]           sample_wdata,
  output logic [TAP_ADDR_W-1:0] coef_addr,
  output logic                  fir_en,
  output logic                  fir_mult_clr,
  output logic                  fir_accum_en,
  output logic                  fir_accum_clr,
  input  logic [47:0]           tap_data_out,
  output logic [47:0]           result,
  output logic                  result_valid
);

  localparam int CNT_W = TAP_ADDR_W + 1;
  localparam logic [CNT_W-1:0]      TAPS_N     = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0]      TAPS_LAST  = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(RD_LAT + MULT_LAT - 1);
  localparam logic [CNT_W-1:0]      CAPT_LAST  = CNT_W'(1);
  localparam logic [TAP_ADDR_W-1:0] PTR_LAST   = TAP_ADDR_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_WRITE, ST_ISSUE, ST_DRAIN, ST_DUMP, ST_CAPTURE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt, w_k_nxt, w_ptr_ext, w_rd_addr_ext;
  logic [TAP_ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic                  r_issue_vld;
  logic [RD_LAT-1:0]     r_en_pipe;
  logic [MULT_LAT-1:0]   r_acc_pipe;

  logic                  w_busy, w_overrun, w_we, w_mclr, w_aclr, w_issue, w_rv;
  logic [TAP_ADDR_W-1:0] w_addr, w_coef;
  logic [23:0]           w_wdata;
  logic [47:0]           w_result;

  assign fir_en       = r_en_pipe[RD_LAT-1];
  assign fir_accum_en = r_acc_pipe[MULT_LAT-1];

  // Output registers load the values belonging to the state being entered,
  // so every strobe lines up with the state it describes.
  always_comb begin
    // NOTE: every signal is given a default first so no path through the case infers a latch.
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wr_ptr_nxt = r_wr_ptr;
    w_busy       = 1'b1;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    w_coef       = '0;
    w_mclr       = 1'b0;
    w_aclr       = 1'b0;
    w_issue      = 1'b0;
    w_rv         = 1'b0;
    w_result     = result;
    w_overrun    = overrun | (sample_valid & (r_state != ST_IDLE)
                              & ~((r_state == ST_INIT) & (r_cnt == '0)));
    w_k_nxt       = r_cnt + CNT_W'(1);
    w_ptr_ext     = {1'b0, r_wr_ptr};
    w_rd_addr_ext = (w_ptr_ext >= w_k_nxt) ? (w_ptr_ext - w_k_nxt)
                                            : (w_ptr_ext + TAPS_N - w_k_nxt);

    unique case (r_state)
      ST_INIT: begin
        if (r_cnt == TAPS_N) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_busy      = 1'b0;
        end else begin
          w_cnt_nxt = w_k_nxt;
          w_we      = 1'b1;
          w_addr    = r_cnt[TAP_ADDR_W-1:0];
          w_mclr    = 1'b1;
          w_aclr    = 1'b1;
        end
      end
      ST_IDLE: begin
        w_busy = 1'b0;
        if (sample_valid) begin
          w_state_nxt = ST_WRITE;
          w_busy      = 1'b1;
          w_we        = 1'b1;
          w_addr      = r_wr_ptr;
          w_wdata     = sample_in;
          w_mclr      = 1'b1;
        end
      end
      ST_WRITE: begin
        w_state_nxt = ST_ISSUE;
        w_cnt_nxt   = '0;
        w_issue     = 1'b1;
        w_addr      = r_wr_ptr;
      end
      ST_ISSUE: begin
        if (r_cnt == TAPS_LAST) begin
          w_state_nxt  = ST_DRAIN;
          w_cnt_nxt    = '0;
          w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + TAP_ADDR_W'(1);
        end else begin
          w_cnt_nxt = w_k_nxt;
          w_issue   = 1'b1;
          w_coef    = w_k_nxt[TAP_ADDR_W-1:0];
          w_addr    = w_rd_addr_ext[TAP_ADDR_W-1:0];
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = ST_DUMP;
          w_cnt_nxt   = '0;
          w_aclr      = 1'b1;
        end else begin
          w_cnt_nxt = w_k_nxt;
        end
      end
      ST_DUMP: begin
        w_state_nxt = ST_CAPTURE;
        w_cnt_nxt   = '0;
      end
      ST_CAPTURE: begin
        // The tap's data_out settles one cycle after the dump edge.
        if (r_cnt == CAPT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_busy      = 1'b0;
          w_rv        = 1'b1;
          w_result    = tap_data_out;
        end else begin
          w_cnt_nxt = w_k_nxt;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_INIT;
      r_cnt         <= '0;
      r_wr_ptr      <= '0;
      r_issue_vld   <= 1'b0;
      r_en_pipe     <= '0;
      r_acc_pipe    <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      sample_we     <= 1'b0;
      sample_addr   <= '0;
      sample_wdata  <= '0;
      coef_addr     <= '0;
      fir_mult_clr  <= 1'b0;
      fir_accum_clr <= 1'b0;
      result        <= '0;
      result_valid  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_issue_vld   <= w_issue;
      r_en_pipe[0]  <= r_issue_vld;
      for (int i = 1; i < RD_LAT; i++) r_en_pipe[i] <= r_en_pipe[i-1];
      r_acc_pipe[0] <= fir_en;
      for (int i = 1; i < MULT_LAT; i++) r_acc_pipe[i] <= r_acc_pipe[i-1];
      busy          <= w_busy;
      overrun       <= w_overrun;
      sample_we     <= w_we;
      sample_addr   <= w_addr;
      sample_wdata  <= w_wdata;
      coef_addr     <= w_coef;
      fir_mult_clr  <= w_mclr;
      fir_accum_clr <= w_aclr;
      result        <= w_result;
      result_valid  <= w_rv;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: RAM and tap models around the DUT, results
// compared against a sample-history convolution model.
module tb_fir_tap_sequencer;

  localparam int AW       = 8;
  localparam int N        = 256;
  localparam int RD_LAT   = 1;
  localparam int MULT_LAT = 3;
  localparam int RV_LAT   = N + RD_LAT + MULT_LAT + 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [23:0]   sample_in = '0;
  logic          busy, overrun, sample_we, fir_en, fir_mult_clr, fir_accum_en, fir_accum_clr;
  logic [AW-1:0] sample_addr, coef_addr;
  logic [23:0]   sample_wdata;
  logic [47:0]   tap_data_out = '0;
  logic [47:0]   result;
  logic          result_valid;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_wr = '0;
  logic          exp_ovr = 1'b0;
  logic [23:0]   hist[$];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.TAP_ADDR_W(AW), .NUM_TAPS(N), .RD_LAT(RD_LAT), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .busy(busy), .overrun(overrun), .sample_we(sample_we), .sample_addr(sample_addr),
    .sample_wdata(sample_wdata), .coef_addr(coef_addr), .fir_en(fir_en),
    .fir_mult_clr(fir_mult_clr), .fir_accum_en(fir_accum_en), .fir_accum_clr(fir_accum_clr),
    .tap_data_out(tap_data_out), .result(result), .result_valid(result_valid)
  );

  // Delay-line RAM, coefficient ROM (coef[k] = k+1) and FIR_Tap behaviour.
  logic [23:0]        dl_ram [N];
  logic signed [23:0] rd_s = '0;
  logic signed [23:0] rd_c = '0;
  logic signed [47:0] prod_q[$];
  logic signed [47:0] acc = '0;

  function automatic logic signed [47:0] mul(input logic signed [23:0] a, input logic signed [23:0] b);
    return a * b;
  endfunction

  function automatic logic signed [47:0] tap_term(input logic signed [47:0] p);
    return {{16{p[39]}}, p[39:8]};
  endfunction

  always @(posedge clk) begin
    if (sample_we) dl_ram[sample_addr] <= sample_wdata;
    rd_s <= dl_ram[sample_addr];
    rd_c <= {16'd0, coef_addr} + 24'd1;
    if (fir_mult_clr) prod_q.delete();
    else if (fir_en) prod_q.push_back(mul(rd_s, rd_c));
    if (fir_accum_clr) begin
      tap_data_out <= acc;
      acc          <= '0;
    end else if (fir_accum_en && prod_q.size() > 0) begin
      acc <= acc + tap_term(prod_q.pop_front());
    end
  end

  // Reference: filter output is the sum over taps k of (hist[k] * (k+1)) >> 8,
  // keeping bits 39:8 of each product, with hist[0] the newest sample.
  function automatic logic [47:0] ref_result();
    longint sum = 0;
    for (int k = 0; k < N; k++) begin
      int     s = {{8{hist[k][23]}}, hist[k]};
      longint p = longint'(s) * longint'(k + 1);
      sum += longint'(int'(p >>> 8));
    end
    return sum[47:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {busy, overrun, sample_we, sample_addr, sample_wdata, coef_addr, fir_en,
              fir_mult_clr, fir_accum_en, fir_accum_clr, result_valid}, 64'd0);
    chk({tag, "_result"}, result, 64'd0);
  endtask

  task automatic check_init();
    int n = 0;
    int bad = 0;
    for (int t = 0; t < N + 20; t++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (result_valid) bad++;
      if (sample_we) begin
        if (sample_addr != n[AW-1:0] || sample_wdata != 24'd0 || !busy ||
            !fir_accum_clr || !fir_mult_clr) bad++;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    chk("init_we_cycles", n, N);
    chk("init_strobes", bad, 0);
    chk("init_idle_busy", busy, 0);
    chk("init_overrun", overrun, 0);
    hist.delete();
    for (int k = 0; k < N; k++) hist.push_back(24'd0);
    exp_wr = '0;
  endtask

  // Drives one sample from an IDLE negedge and follows it to result_valid.
  // ovr_at injects a stray sample_valid in that cycle; rst_at asserts reset there.
  task automatic send(input logic [23:0] s, input int ovr_at, input int rst_at);
    int          rv_t = -1, en_n = 0, acc_n = 0, clr_n = 0, clr_t = -1;
    int          en_first = -1, en_last = -1, acc_first = -1, acc_last = -1;
    int          addr_bad = 0, busy_bad = 0;
    logic [47:0] exp_res;
    hist.push_front(s);
    void'(hist.pop_back());
    exp_res      = ref_result();
    sample_in    = s;
    sample_valid = 1'b1;
    for (int t = 1; t <= RV_LAT + 20; t++) begin
      @(negedge clk);
      if (t == 1) sample_valid = 1'b0;
      if (t == 1)
        chk("write_cycle", {sample_we, fir_mult_clr, busy, sample_addr, sample_wdata},
                           {1'b1, 1'b1, 1'b1, exp_wr, s});
      if (t == rst_at) begin
        chk("reset_point_coef", coef_addr, t - 2);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("reset_async_outputs");
        return;
      end
      if (t == ovr_at) begin
        chk("overrun_before", overrun, exp_ovr);
        sample_valid = 1'b1;
        exp_ovr      = 1'b1;
      end
      if (t == ovr_at + 1) sample_valid = 1'b0;
      if (t >= 2 && t <= N + 1) begin
        int k = t - 2;
        int a = (int'(exp_wr) - k + N) % N;
        if (sample_addr != a[AW-1:0] || coef_addr != k[AW-1:0] || sample_we) addr_bad++;
      end
      if (fir_en) begin
        en_n++;
        if (en_first < 0) en_first = t;
        en_last = t;
      end
      if (fir_accum_en) begin
        acc_n++;
        if (acc_first < 0) acc_first = t;
        acc_last = t;
      end
      if (fir_accum_clr) begin
        clr_n++;
        clr_t = t;
      end
      if (result_valid) begin
        rv_t = t;
        break;
      end
      if (!busy) busy_bad++;
    end
    chk("rv_latency", rv_t, RV_LAT);
    chk("rv_busy_low", busy, 0);
    chk("result", result, exp_res);
    chk("busy_gaps", busy_bad, 0);
    chk("issue_addrs", addr_bad, 0);
    chk("fir_en_count", en_n, N);
    chk("fir_en_first", en_first, 2 + RD_LAT);
    chk("fir_en_last", en_last, N + 1 + RD_LAT);
    chk("accum_en_count", acc_n, N);
    chk("accum_en_offset", acc_first - en_first, MULT_LAT);
    chk("accum_en_last", acc_last, N + 1 + RD_LAT + MULT_LAT);
    chk("accum_clr_count", clr_n, 1);
    chk("accum_clr_cycle", clr_t, N + 2 + RD_LAT + MULT_LAT);
    chk("overrun_flag", overrun, exp_ovr);
    exp_wr = exp_wr + AW'(1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");

    // sample_valid coincident with reset release must be ignored
    sample_in    = 24'h123456;
    sample_valid = 1'b1;
    reset_n      = 1'b1;
    check_init();

    // impulse walks through every coefficient, wrapping wr_ptr 255 -> 0
    for (int i = 0; i <= N; i++) begin
      send((i == 0) ? 24'h000100 : 24'h000000, 0, 0);
      chk("impulse_value", result, (i < N) ? i + 1 : 0);
    end

    for (int i = 0; i < 4; i++) send(24'($urandom), 0, 0);

    // stray sample during ISSUE is dropped and flagged
    send(24'($urandom), 100, 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result_valid || busy) quiet++;
    end
    chk("overrun_no_extra", quiet, 0);
    chk("overrun_sticky", overrun, 1);
    send(24'($urandom), 0, 0);
    send(24'($urandom), 0, 0);

    // reset during ISSUE at k=100
    send(24'($urandom), 0, 102);
    quiet = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (result_valid || busy) quiet++;
    end
    chk("reset_hold_quiet", quiet, 0);
    exp_ovr = 1'b0;
    reset_n = 1'b1;
    check_init();
    send(24'h000100, 0, 0);
    chk("post_reset_impulse", result, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Control initiator for the FIR_Tap multiply-accumulate datapath. Per incoming 24-bit audio sample it writes the sample into an external circular delay-line RAM, then walks NUM_TAPS coefficient/sample address pairs. It drives the tap's `fir_en`, `fir_accum_en`, `fir_mult_clr` and `fir_accum_clr` strobes, aligned to RAM read latency and multiplier latency, and captures the tap's 48-bit `data_out` as the filter result. It sits between the I2S sample stream and the FIR_Tap instance.

## Interface
- Parameters:
- TAP_ADDR_W, 8, address width of the delay-line and coefficient RAMs
- NUM_TAPS, 256, number of taps; must satisfy 2 <= NUM_TAPS <= 2^TAP_ADDR_W
- RD_LAT, 1, read latency of both RAMs (address to data) in cycles
- MULT_LAT, 3, cycles from `fir_en` to a valid product at the accumulator input
- Ports:
- clk  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe: `sample_in` holds a new sample
- sample_in  in  24  signed audio sample
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: a sample was dropped; cleared only by reset
- sample_we  out  1  delay-line RAM write enable
- sample_addr  out  TAP_ADDR_W  delay-line RAM address, used for both write and read
- sample_wdata  out  24  delay-line RAM write data
- coef_addr  out  TAP_ADDR_W  coefficient RAM read address
- fir_en  out  1  multiplier clock enable to the tap
- fir_mult_clr  out  1  multiplier synchronous clear to the tap
- fir_accum_en  out  1  accumulator enable to the tap
- fir_accum_clr  out  1  accumulator clear and output-hold strobe to the tap
- tap_data_out  in  48  `data_out` from the tap
- result  out  48  last filter result
- result_valid  out  1  one-cycle pulse: `result` is updated

## Operation
- All outputs and all state are registered. Reset drives every output to 0, `wr_ptr` to 0, and the state to INIT.
- INIT:
  - Lasts NUM_TAPS cycles.
  - `sample_we`=1, `sample_wdata`=0, `sample_addr` counts 0..NUM_TAPS-1 (zeroes the delay line).
  - `fir_mult_clr`=`fir_accum_clr`=1 throughout.
  - Then go to IDLE.
- IDLE:
  - When `sample_valid`=1, register `sample_in` and go to WRITE.
  - `sample_valid` in any other state drops the sample and sets `overrun`.
- WRITE:
  - One cycle: `sample_we`=1, `sample_addr`=`wr_ptr`, `sample_wdata`=registered sample, `fir_mult_clr`=1.
  - Then ISSUE.
- ISSUE:
  - Lasts NUM_TAPS cycles, k=0..NUM_TAPS-1.
  - `coef_addr`=k.
  - `sample_addr`=(`wr_ptr`-k) mod NUM_TAPS, i.e. `wr_ptr`-k if `wr_ptr`>=k, else `wr_ptr`+NUM_TAPS-k.
  - A valid bit enters a delay pipe.
- Strobe timing:
  - `fir_en` = issue-valid delayed RD_LAT cycles.
  - `fir_accum_en` = `fir_en` delayed MULT_LAT cycles.
  - A tap product is accumulated only when `fir_accum_en`=1.
- DRAIN:
  - Wait until the pipe is empty, plus one cycle for the accumulator Q to settle.
  - `wr_ptr` increments mod NUM_TAPS on leaving ISSUE.
- DUMP:
  - `fir_accum_clr`=1 for exactly one cycle.
  - The tap latches the final sum into `data_out` and clears its accumulator at the same edge.
- CAPTURE:
  - `result` <= `tap_data_out`; `result_valid`=1 on the following cycle.
  - Return to IDLE.
- Arithmetic: the sequencer does no arithmetic on data. The result format is the tap's: sum of (product[39:8]) over all taps, 48 bits.

## Timing
- Define cycle 0 as the IDLE cycle in which `sample_valid` is accepted.
- WRITE is at cycle 1; ISSUE is cycles 2..NUM_TAPS+1.
- Last `fir_en`: cycle NUM_TAPS+1+RD_LAT.
- Last `fir_accum_en`: cycle NUM_TAPS+1+RD_LAT+MULT_LAT.
- `fir_accum_clr`: cycle NUM_TAPS+2+RD_LAT+MULT_LAT.
- `result_valid`: cycle NUM_TAPS+RD_LAT+MULT_LAT+5 (265 at defaults).
- `busy`: high from cycle 1 through the cycle before `result_valid`. It is low in the `result_valid` cycle, where a new sample may be accepted.
- `fir_en` and `fir_accum_en` are each high for exactly NUM_TAPS cycles per sample, contiguous.
- `fir_accum_clr` pulses once per sample outside of INIT.
- Reset asserted mid-operation:
  - Outputs go to 0 immediately (asynchronously).
  - Any partial result is discarded; no `result_valid` is issued.
  - INIT reruns after release.
- `sample_valid` arriving together with a reset release is ignored.

## Test plan
- Reset release:
  - `sample_we`=1 for exactly 256 cycles with addr 0..255 and data 0; `busy`=1, `fir_accum_clr`=1 throughout.
  - Then IDLE with `busy`=0; all outputs are 0 while `reset_n`=0.
- Impulse (behavioural tap and RAM models, coef[k]=k+1):
  - Send 0x000100, then zeros, each after the previous `result_valid`.
  - Required results: 1, 2, 3, ... 256, then 0.
- Latency and counts at defaults:
  - `result_valid` exactly 265 cycles after acceptance.
  - Exactly 256 `fir_en` cycles and 256 `fir_accum_en` cycles per sample.
  - First `fir_accum_en` exactly 3 cycles after first `fir_en`; one `fir_accum_clr` pulse.
- Wrap: with `wr_ptr`=3, the ISSUE `sample_addr` sequence is 3,2,1,0,255,...,4; the next sample is written at 4, and at 0 after 255.
- Overrun:
  - `sample_valid` during ISSUE sets `overrun`=1 (sticky); `wr_ptr` is unchanged and no extra `result_valid` occurs.
  - The next accepted sample yields the correct result.
- Reset mid-ISSUE (k=100):
  - Outputs go to 0 within the reset-assert cycle and no `result_valid` occurs.
  - INIT repeats; the next impulse gives result 1.
